// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // Bit counter width; counts 0..width-1, so a power-of-two width never aliases.
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full adder, the only arithmetic in the serial datapath.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one operand pair in, LSB-first through one
// full-adder cell, result handed out over a second valid/ready handshake.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here depend on state only, never on the peer's signal.

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa      <= '0;
            opb      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is A + ~B + 1, so the inverted B and forced carry do it.
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa    <= opa >> 1;
                    opb    <= opb >> 1;
                    result <= {fa_s, result[WIDTH-1:1]};
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // Separate output register keeps sum stable while result shifts.
                        sum      <= {fa_s, result[WIDTH-1:1]};
                        cout     <= fa_co;
                        overflow <= carry ^ fa_co;
                        cnt      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             busy;

    int checks = 0;
    int errors = 0;
    logic [WIDTH+1:0] exp_q[$];

    int   since_acc = -1;
    logic ov_prev = 1'b0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {overflow, cout, sum} from plain integer arithmetic on the operands.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] r;
        logic             v;
        if (s) begin
            full = {1'b0, x} + {1'b0, ~y} + 1;
            r    = full[WIDTH-1:0];
            v    = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
            r    = full[WIDTH-1:0];
            v    = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        end
        return {v, full[WIDTH], r};
    endfunction

    // Counting the accepting edge, out_valid must first be seen after WIDTH+1 edges.
    always @(negedge clk) begin
        if (!rst_n) begin
            since_acc = -1;
            ov_prev   = 1'b0;
        end else begin
            if (since_acc >= 0) since_acc++;
            if (out_valid && !ov_prev) begin
                check("latency_mon", 64'(since_acc), 64'(WIDTH + 1));
                since_acc = -1;
            end
            if (in_valid && in_ready) since_acc = 0;
            ov_prev = out_valid;
        end
    end

    // Present a pair and hold it until accepted; returns just after the accepting edge.
    task automatic start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input logic s);
        bit done = 0;
        a = x; b = y; cin = c; sub = s;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_result(input string tag);
        logic [WIDTH+1:0] e;
        int n = 0;
        e = exp_q.pop_front();
        for (int i = 1; i <= WIDTH + 4 && n == 0; i++) begin
            @(posedge clk); #1;
            if (out_valid) n = i;
        end
        check({tag, "_latency"}, 64'(n), 64'(WIDTH));
        check({tag, "_result"}, {54'd0, overflow, cout, sum}, {54'd0, e});
    endtask

    task automatic take(input int gap);
        for (int i = 0; i < gap && !out_ready; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid", 64'(out_valid), 64'd0);
        check("handoff_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;

        // Reset state, checked while rst_n is still low.
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", {54'd0, overflow, cout, sum}, 64'd0);
        #24 rst_n = 1'b1;
        @(posedge clk); #1;

        // Add with signed overflow.
        exp_q.push_back({1'b1, 1'b0, 8'h96});
        start(8'h5A, 8'h3C, 1'b0, 1'b0);
        wait_result("add_ovf");
        take(2);

        // Unsigned wrap, and carry-in alone.
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        start(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_result("add_wrap");
        take(0);
        exp_q.push_back({1'b0, 1'b0, 8'h01});
        start(8'h00, 8'h00, 1'b1, 1'b0);
        wait_result("add_cin");
        take(1);

        // Subtract: cin ignored, then signed overflow with no borrow.
        exp_q.push_back({1'b0, 1'b0, 8'hF0});
        start(8'h10, 8'h20, 1'b1, 1'b1);
        wait_result("sub_borrow");
        take(0);
        exp_q.push_back({1'b1, 1'b1, 8'h7F});
        start(8'h80, 8'h01, 1'b0, 1'b1);
        wait_result("sub_ovf");
        take(0);

        // Backpressure in DONE with a stray in_valid pulse.
        exp_q.push_back({1'b0, 1'b0, 8'h07});
        start(8'h03, 8'h04, 1'b0, 1'b0);
        wait_result("bp_first");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            end
            if (i == 2) in_valid = 1'b0;
            @(posedge clk); #1;
            check("bp_hold", {54'd0, overflow, cout, sum}, {54'd0, 2'b00, 8'h07});
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
        end
        take(0);
        exp_q.push_back({1'b0, 1'b0, 8'h33});
        start(8'h11, 8'h22, 1'b0, 1'b0);
        wait_result("bp_second");
        take(0);

        // Asynchronous reset after three RUN cycles.
        start(8'hAA, 8'h55, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sum", 64'(sum), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_release_ready", 64'(in_ready), 64'd1);
        exp_q.push_back({1'b0, 1'b0, 8'h03});
        start(8'h01, 8'h02, 1'b0, 1'b0);
        wait_result("arst_after");
        take(0);

        // Random transactions with gaps and input churn during RUN.
        for (int t = 0; t < 1000; t++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                @(posedge clk); #1;
            end
            exp_q.push_back(model(ra, rb, rc, rs));
            start(ra, rb, rc, rs);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) == 0);
            wait_result("rand");
            take($urandom_range(0, 3));
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
